// File: rtl/alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_iter                                                      |
// | Purpose  : Registered execute-stage ALU with start/busy/done handshake.  |
// |            Logic, add/sub and compare ops finish in one cycle; MULTU     |
// |            (shift-add) and DIVU (restoring) take WIDTH cycles and also   |
// |            return a HI word. Flags are registered together with result.  |
// | Options  : ALU_DIV_EN - build the DIVU datapath; when undefined, gin=1001 |
// |            is treated as an unknown single-cycle op.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             zout,
  output logic             vout,
  output logic             nout
);

  localparam int            C_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(WIDTH - 1);

  localparam logic [3:0] C_OP_AND   = 4'b0000;
  localparam logic [3:0] C_OP_OR    = 4'b0001;
  localparam logic [3:0] C_OP_ADD   = 4'b0010;
  localparam logic [3:0] C_OP_NOR   = 4'b0011;
  localparam logic [3:0] C_OP_XOR   = 4'b0100;
  localparam logic [3:0] C_OP_SLTU  = 4'b0101;
  localparam logic [3:0] C_OP_SUB   = 4'b0110;
  localparam logic [3:0] C_OP_SLT   = 4'b0111;
  localparam logic [3:0] C_OP_MULTU = 4'b1000;
`ifdef ALU_DIV_EN
  localparam logic [3:0] C_OP_DIVU  = 4'b1001;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  hi_q;
  logic              busy_q;
  logic              done_q;
  logic              zout_q;
  logic              vout_q;
  logic              nout_q;
  // acc_q: partial product high half / partial remainder
  // lo_q : multiplier shifting out / dividend shifting out, quotient in
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  opb_q;
  logic [C_CW-1:0]   cnt_q;
`ifdef ALU_DIV_EN
  logic              is_div_q;
  logic              bzero_q;
`endif

  logic [WIDTH-1:0]  sum_w;
  logic [WIDTH-1:0]  diff_w;
  logic [WIDTH-1:0]  alu_res_d;
  logic              alu_v_d;
  logic              iter_op_w;
  logic [WIDTH:0]    mul_sum_w;
  logic [WIDTH-1:0]  step_acc_d;
  logic [WIDTH-1:0]  step_lo_d;
  logic              fin_z_w;
  logic              fin_v_w;

  assign sum_w  = a + b;
  assign diff_w = a - b;

  // Single-cycle result and overflow for every non-iterative code
  always_comb begin
    alu_res_d = '0;
    alu_v_d   = 1'b0;
    case (gin)
      C_OP_AND:  alu_res_d = a & b;
      C_OP_OR:   alu_res_d = a | b;
      C_OP_NOR:  alu_res_d = ~(a | b);
      C_OP_XOR:  alu_res_d = a ^ b;
      C_OP_ADD: begin
        alu_res_d = sum_w;
        alu_v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      C_OP_SUB: begin
        alu_res_d = diff_w;
        alu_v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      C_OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (a < b)};
      // Native signed compare: no subtract, so no wrap error at the extremes
      C_OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:   alu_res_d = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  assign iter_op_w = (gin == C_OP_MULTU) || (gin == C_OP_DIVU);
`else
  assign iter_op_w = (gin == C_OP_MULTU);
`endif

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the {carry,acc,lo} product right.
  assign mul_sum_w = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

`ifdef ALU_DIV_EN
  logic [WIDTH:0] div_shift_w;
  logic [WIDTH:0] div_trial_w;

  // The partial remainder stays below the divisor, so the shifted value is
  // below 2*divisor and the trial difference's top bit is a clean borrow.
  assign div_shift_w = {acc_q, lo_q[WIDTH-1]};
  assign div_trial_w = div_shift_w - {1'b0, opb_q};

  // One iteration of either the multiplier or the restoring divider
  always_comb begin
    step_acc_d = mul_sum_w[WIDTH:1];
    step_lo_d  = {mul_sum_w[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_trial_w[WIDTH]) begin
        step_acc_d = div_trial_w[WIDTH-1:0];
        step_lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc_d = div_shift_w[WIDTH-1:0];
        step_lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // A zero divisor naturally yields all-ones quotient and remainder=a;
  // only the overflow flag needs the remembered b==0 condition.
  assign fin_v_w = is_div_q ? bzero_q : (step_acc_d != '0);
  assign fin_z_w = is_div_q ? (step_lo_d == '0) : ({step_acc_d, step_lo_d} == '0);
`else
  // One iteration of the multiplier
  always_comb begin
    step_acc_d = mul_sum_w[WIDTH:1];
    step_lo_d  = {mul_sum_w[0], lo_q[WIDTH-1:1]};
  end

  assign fin_v_w = (step_acc_d != '0);
  assign fin_z_w = ({step_acc_d, step_lo_d} == '0);
`endif

  // Control FSM plus all registered outputs and iterative datapath state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zout_q   <= 1'b0;
      vout_q   <= 1'b0;
      nout_q   <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (iter_op_w) begin
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
              acc_q    <= '0;
              lo_q     <= a;
              opb_q    <= b;
              cnt_q    <= '0;
`ifdef ALU_DIV_EN
              is_div_q <= (gin == C_OP_DIVU);
              bzero_q  <= (b == '0);
`endif
            end else begin
              result_q <= alu_res_d;
              hi_q     <= '0;
              vout_q   <= alu_v_d;
              zout_q   <= (alu_res_d == '0);
              nout_q   <= alu_res_d[WIDTH-1];
              done_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc_q <= step_acc_d;
          lo_q  <= step_lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_CNT_LAST) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= step_lo_d;
            hi_q     <= step_acc_d;
            zout_q   <= fin_z_w;
            vout_q   <= fin_v_w;
            nout_q   <= step_lo_d[WIDTH-1];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign zout   = zout_q;
  assign vout   = vout_q;
  assign nout   = nout_q;

endmodule
`default_nettype wire
